// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared types and helpers for the PC redirect controller: word size, FSM and
// request-kind encodings, and the immediate sign-extension function.
package pc_redirect_ctrl_pkg;

  localparam int WORD_SIZE = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_JALR_WAIT,
    S_REDIRECT
  } state_e;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_BR,
    REQ_JALR,
    REQ_JAL
  } req_kind_e;

  // Sign-extends the low 'width' bits of imm (width <= 21) to a full word.
  function automatic logic [WORD_SIZE-1:0] sign_extend(input logic [20:0] imm,
                                                       input int width);
    logic signed [WORD_SIZE-1:0] v;
    v = signed'({{(WORD_SIZE-21){1'b0}}, imm}) <<< (WORD_SIZE - width);
    return v >>> (WORD_SIZE - width);
  endfunction

endpackage

// File: rtl/redirect_target_gen.sv
// Combinational PC-relative target adder for taken branches and JAL:
// target = pc + sign-extended immediate, modulo 2^32.
module redirect_target_gen
  import pc_redirect_ctrl_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic        i_is_jal,
  input  logic [12:0] i_br_imm,
  input  logic [20:0] i_jal_imm,
  output logic [31:0] o_target
);

  logic [31:0] w_offset;

  always_comb begin
    if (i_is_jal) w_offset = sign_extend(i_jal_imm, 21);
    else          w_offset = sign_extend({8'b0, i_br_imm}, 13);
  end

  assign o_target = i_pc + w_offset;

endmodule

// File: rtl/pc_redirect_ctrl.sv
// PC redirect controller: arbitrates branch/JALR/JAL requests, sequences the
// external JALR adder and issues a one-cycle redirect. Optional MISALIGN_TRAP_EN.
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        br_req,
  input  logic [12:0] br_imm,
  input  logic        jalr_req,
  input  logic [31:0] jalr_rs1,
  input  logic [11:0] jalr_imm,
  input  logic        jal_req,
  input  logic [20:0] jal_imm,
  output logic [11:0] adder_imm,
  output logic [31:0] adder_reg,
  input  logic [31:0] adder_result,
  output logic        stall,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        link_we,
  output logic [31:0] link_addr,
  output logic        misalign_fault,
  output logic [15:0] redirect_count
);

  state_e      r_state;
  state_e      w_next_state;
  req_kind_e   w_kind;
  req_kind_e   r_kind;
  logic [31:0] r_pc;
  logic [31:0] r_rs1;
  logic [31:0] r_target;
  logic [15:0] r_count;
  logic [31:0] w_bj_target;
  logic        w_accept;
  logic        w_fault;

  redirect_target_gen u_target_gen (
    .i_pc      (pc),
    .i_is_jal  (w_kind == REQ_JAL),
    .i_br_imm  (br_imm),
    .i_jal_imm (jal_imm),
    .o_target  (w_bj_target)
  );

  // Fixed priority; losers are simply dropped.
  always_comb begin
    w_kind = REQ_NONE;
    if (br_req)        w_kind = REQ_BR;
    else if (jalr_req) w_kind = REQ_JALR;
    else if (jal_req)  w_kind = REQ_JAL;
  end

  assign w_accept = (r_state == S_IDLE) && (w_kind != REQ_NONE);

`ifdef MISALIGN_TRAP_EN
  assign w_fault = (r_state == S_REDIRECT) && r_target[1];
`else
  assign w_fault = 1'b0;
`endif

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next_state = (w_kind == REQ_JALR) ? S_JALR_WAIT : S_REDIRECT;
      end
      S_JALR_WAIT: w_next_state = S_REDIRECT;
      S_REDIRECT:  w_next_state = S_IDLE;
      default:     w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_kind   <= REQ_NONE;
      r_pc     <= '0;
      r_rs1    <= '0;
      r_target <= '0;
      r_count  <= '0;
    end else begin
      if (w_accept) begin
        r_kind <= w_kind;
        r_pc   <= pc;
        if (w_kind == REQ_JALR) r_rs1    <= jalr_rs1;
        else                    r_target <= w_bj_target;
      end
      if (r_state == S_JALR_WAIT) r_target <= adder_result;
      if (redirect_valid && (r_count != 16'hFFFF)) r_count <= r_count + 16'd1;
    end
  end

  // NOTE: every output gets a default before the case so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    adder_imm      = jalr_imm;
    adder_reg      = '0;
    stall          = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    link_we        = 1'b0;
    link_addr      = '0;
    case (r_state)
      S_JALR_WAIT: begin
        stall     = 1'b1;
        adder_reg = r_rs1;
      end
      S_REDIRECT: begin
        flush = 1'b1;
        if (!w_fault) begin
          redirect_valid = 1'b1;
          redirect_pc    = r_target;
          if (r_kind != REQ_BR) begin
            link_we   = 1'b1;
            link_addr = r_pc + 32'd4;
          end
        end
      end
      default: ;
    endcase
  end

  assign misalign_fault = w_fault;
  assign redirect_count = r_count;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench for pc_redirect_ctrl: table of directed redirects plus
// hand sequences for reset aborts, ignored/back-to-back requests and misalignment.
module tb_pc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        br_req;
  logic [12:0] br_imm;
  logic        jalr_req;
  logic [31:0] jalr_rs1;
  logic [11:0] jalr_imm;
  logic        jal_req;
  logic [20:0] jal_imm;
  logic [11:0] adder_imm;
  logic [31:0] adder_reg;
  logic [31:0] adder_result;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        link_we;
  logic [31:0] link_addr;
  logic        misalign_fault;
  logic [15:0] redirect_count;

  pc_redirect_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .pc             (pc),
    .br_req         (br_req),
    .br_imm         (br_imm),
    .jalr_req       (jalr_req),
    .jalr_rs1       (jalr_rs1),
    .jalr_imm       (jalr_imm),
    .jal_req        (jal_req),
    .jal_imm        (jal_imm),
    .adder_imm      (adder_imm),
    .adder_reg      (adder_reg),
    .adder_result   (adder_result),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .link_we        (link_we),
    .link_addr      (link_addr),
    .misalign_fault (misalign_fault),
    .redirect_count (redirect_count)
  );

  always #5 clk = ~clk;

  // External one-cycle JALR adder: immediate captured at the accept edge,
  // added to the register operand presented during JALR_WAIT.
  logic [11:0] imm_q;
  always @(posedge clk or posedge reset) begin
    if (reset) imm_q <= '0;
    else       imm_q <= adder_imm;
  end
  assign adder_result = adder_reg + {{20{imm_q[11]}}, imm_q};

  typedef struct {
    logic        br;
    logic        jalr;
    logic        jal;
    logic [31:0] pc;
    logic [12:0] br_imm;
    logic [31:0] rs1;
    logic [11:0] jalr_imm;
    logic [20:0] jal_imm;
    logic        exp_stall;
    logic [31:0] exp_pc;
    logic        exp_link_we;
    logic [31:0] exp_link;
  } vec_t;

  vec_t        vecs[9];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_count = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    pc = '0; br_req = 1'b0; br_imm = '0; jalr_req = 1'b0; jalr_rs1 = '0;
    jalr_imm = '0; jal_req = 1'b0; jal_imm = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " stall"},          {31'b0, stall},          32'h0);
    check({tag, " flush"},          {31'b0, flush},          32'h0);
    check({tag, " redirect_valid"}, {31'b0, redirect_valid}, 32'h0);
    check({tag, " redirect_pc"},    redirect_pc,             32'h0);
    check({tag, " link_we"},        {31'b0, link_we},        32'h0);
    check({tag, " link_addr"},      link_addr,               32'h0);
    check({tag, " misalign_fault"}, {31'b0, misalign_fault}, 32'h0);
    check({tag, " adder_reg"},      adder_reg,               32'h0);
    check({tag, " redirect_count"}, {16'b0, redirect_count}, 32'h0);
  endtask

  task automatic quiet_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("%s idle%0d valid", tag, i), {31'b0, redirect_valid}, 32'h0);
      check($sformatf("%s idle%0d flush", tag, i), {31'b0, flush}, 32'h0);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string t;
    t = $sformatf("vec%0d", idx);
    @(negedge clk);
    pc = v.pc; br_req = v.br; br_imm = v.br_imm; jalr_req = v.jalr;
    jalr_rs1 = v.rs1; jalr_imm = v.jalr_imm; jal_req = v.jal; jal_imm = v.jal_imm;
    #1;
    check({t, " N adder_imm"}, {20'b0, adder_imm}, {20'b0, v.jalr_imm});
    check({t, " N stall"},     {31'b0, stall},     32'h0);
    @(negedge clk);
    drive_idle();
    if (v.exp_stall) begin
      check({t, " wait stall"},     {31'b0, stall},          32'h1);
      check({t, " wait valid"},     {31'b0, redirect_valid}, 32'h0);
      check({t, " wait adder_reg"}, adder_reg,               v.rs1);
      check({t, " wait redir_pc"},  redirect_pc,             32'h0);
      @(negedge clk);
    end
    check({t, " valid"},     {31'b0, redirect_valid}, 32'h1);
    check({t, " flush"},     {31'b0, flush},          32'h1);
    check({t, " stall"},     {31'b0, stall},          32'h0);
    check({t, " redir_pc"},  redirect_pc,             v.exp_pc);
    check({t, " link_we"},   {31'b0, link_we},        {31'b0, v.exp_link_we});
    check({t, " link_addr"}, link_addr,               v.exp_link);
    check({t, " adder_reg"}, adder_reg,               32'h0);
    exp_count++;
    @(negedge clk);
    check({t, " after valid"},   {31'b0, redirect_valid}, 32'h0);
    check({t, " after pc"},      redirect_pc,             32'h0);
    check({t, " after link"},    link_addr,               32'h0);
    check({t, " after count"},   {16'b0, redirect_count}, {16'b0, exp_count});
  endtask

  initial begin
    //          br   jalr jal  pc            br_imm   rs1           jalr_imm jal_imm     stall pc            lwe  link
    vecs[0] = '{1'b0,1'b0,1'b1,32'h0000_0100,13'h0000,32'h0000_0000,12'h000,21'h000020,1'b0,32'h0000_0120,1'b1,32'h0000_0104};
    vecs[1] = '{1'b0,1'b1,1'b0,32'h0000_0200,13'h0000,32'h0000_1000,12'hFFC,21'h000000,1'b1,32'h0000_0FFC,1'b1,32'h0000_0204};
    vecs[2] = '{1'b1,1'b1,1'b1,32'h0000_0040,13'h0010,32'h0000_5555,12'h123,21'h0000FF,1'b0,32'h0000_0050,1'b0,32'h0000_0000};
    vecs[3] = '{1'b1,1'b0,1'b0,32'h0000_1000,13'h1FF0,32'h0000_0000,12'h000,21'h000000,1'b0,32'h0000_0FF0,1'b0,32'h0000_0000};
    vecs[4] = '{1'b0,1'b0,1'b1,32'h0010_0000,13'h0000,32'h0000_0000,12'h000,21'h100000,1'b0,32'h0000_0000,1'b1,32'h0010_0004};
    vecs[5] = '{1'b0,1'b1,1'b1,32'h0000_0300,13'h0000,32'h0000_2000,12'h010,21'h0000FF,1'b1,32'h0000_2010,1'b1,32'h0000_0304};
    vecs[6] = '{1'b1,1'b0,1'b0,32'hFFFF_FFF8,13'h000C,32'h0000_0000,12'h000,21'h000000,1'b0,32'h0000_0004,1'b0,32'h0000_0000};
    vecs[7] = '{1'b0,1'b1,1'b0,32'h0000_0500,13'h0000,32'h0000_0008,12'h800,21'h000000,1'b1,32'hFFFF_F808,1'b1,32'h0000_0504};
    vecs[8] = '{1'b0,1'b0,1'b1,32'h0000_0400,13'h0000,32'h0000_0000,12'h000,21'h0FFFFC,1'b0,32'h0010_03FC,1'b1,32'h0000_0404};

    reset = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    check("reset adder_imm", {20'b0, adder_imm}, 32'h0);
    reset = 1'b0;

    // Reset while waiting on the JALR adder aborts the redirect.
    @(negedge clk);
    pc = 32'h200; jalr_req = 1'b1; jalr_rs1 = 32'h1000; jalr_imm = 12'hFFC;
    @(negedge clk);
    drive_idle();
    check("rst_jw pre stall", {31'b0, stall}, 32'h1);
    #2 reset = 1'b1;
    #1 check_all_zero("rst_jw");
    @(negedge clk);
    reset = 1'b0;
    quiet_cycles("rst_jw", 3);
    check("rst_jw count", {16'b0, redirect_count}, 32'h0);

    // Reset in the middle of the redirect cycle.
    @(negedge clk);
    pc = 32'h100; jal_req = 1'b1; jal_imm = 21'h20;
    @(negedge clk);
    drive_idle();
    check("rst_rd pre valid", {31'b0, redirect_valid}, 32'h1);
    #2 reset = 1'b1;
    #1 check_all_zero("rst_rd");
    @(negedge clk);
    reset = 1'b0;
    quiet_cycles("rst_rd", 3);
    check("rst_rd count", {16'b0, redirect_count}, 32'h0);

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Requests while busy are ignored; one held into the following IDLE is taken.
    @(negedge clk);
    pc = 32'h600; jalr_req = 1'b1; jalr_rs1 = 32'h3000; jalr_imm = 12'h004;
    @(negedge clk);
    check("b2b wait stall", {31'b0, stall}, 32'h1);
    drive_idle();
    pc = 32'h900; br_req = 1'b1; br_imm = 13'h010; jal_req = 1'b1; jal_imm = 21'h40;
    @(negedge clk);
    check("b2b r1 valid", {31'b0, redirect_valid}, 32'h1);
    check("b2b r1 pc",    redirect_pc,             32'h3004);
    check("b2b r1 link",  link_addr,               32'h604);
    check("b2b r1 stall", {31'b0, stall},          32'h0);
    exp_count++;
    drive_idle();
    pc = 32'hA00; jal_req = 1'b1; jal_imm = 21'h40;
    @(negedge clk);
    check("b2b idle valid", {31'b0, redirect_valid}, 32'h0);
    check("b2b idle stall", {31'b0, stall},          32'h0);
    check("b2b idle count", {16'b0, redirect_count}, {16'b0, exp_count});
    @(negedge clk);
    drive_idle();
    check("b2b r2 valid", {31'b0, redirect_valid}, 32'h1);
    check("b2b r2 pc",    redirect_pc,             32'hA40);
    check("b2b r2 link",  link_addr,               32'hA04);
    exp_count++;
    @(negedge clk);
    check("b2b end count", {16'b0, redirect_count}, {16'b0, exp_count});

    // JALR target with bit 1 set.
    @(negedge clk);
    pc = 32'h700; jalr_req = 1'b1; jalr_rs1 = 32'h1000; jalr_imm = 12'h002;
    @(negedge clk);
    drive_idle();
    check("mis stall", {31'b0, stall}, 32'h1);
    @(negedge clk);
`ifdef MISALIGN_TRAP_EN
    check("mis fault",   {31'b0, misalign_fault}, 32'h1);
    check("mis valid",   {31'b0, redirect_valid}, 32'h0);
    check("mis flush",   {31'b0, flush},          32'h1);
    check("mis link_we", {31'b0, link_we},        32'h0);
    check("mis pc",      redirect_pc,             32'h0);
`else
    check("mis fault",   {31'b0, misalign_fault}, 32'h0);
    check("mis valid",   {31'b0, redirect_valid}, 32'h1);
    check("mis pc",      redirect_pc,             32'h1002);
    check("mis link",    link_addr,               32'h704);
    exp_count++;
`endif
    @(negedge clk);
    check("mis count", {16'b0, redirect_count}, {16'b0, exp_count});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
